button_event_debouncer: RTL and testbench

Multi-channel successor to the single-input reset-button debouncer. It generalises channel count and all timing thresholds. Each raw active-low button is synchronised, debounced and classified into press, release, click, double-press and long-press events, all as single-cycle pulses. It sits on the system clock domain, after the PLL, and feeds control logic such as reset requests and mode selection.

---
 rtl/button_event_debouncer.sv | 160 ++++++++++++++++
 tb/tb_button_event_debouncer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_debouncer.sv
// Multi-channel active-low button front end: 2-flop synchroniser, debouncer and press/release/click/double/long classifier.
// Define BUTTON_EVENT_DOUBLE_PRESS_EN to enable double-press detection; otherwise a release after a short press clicks at once.
module button_event_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 5000000,
  parameter int DOUBLE_WINDOW   = 2500000,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button_n_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] click_pulse,
  output logic [CHANNELS-1:0] double_pulse,
  output logic [CHANNELS-1:0] long_pulse
);

`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
  typedef enum logic [2:0] {IDLE, HELD, LONG, WAIT2, HELD2} state_t;
  localparam logic [CNT_WIDTH-1:0] WIN_LAST = CNT_WIDTH'(DOUBLE_WINDOW - 1);
`else
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
`endif

  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

  if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || DOUBLE_WINDOW < 1 || CNT_WIDTH < 1)
  begin : g_param_check
    $error("button_event_debouncer: illegal parameter value");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic                 sync1, sync2;
    logic                 level_q, press_q, release_q, click_q, long_q;
    logic [CNT_WIDTH-1:0] deb_cnt;
    logic [CNT_WIDTH-1:0] hold_cnt;
    logic                 pressed_sync, deb_flip, press_ev, release_ev;
    state_t               state_q;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
    logic                 double_q;
    logic [CNT_WIDTH-1:0] win_cnt;
`endif

    // Sync flops reset to 1 so a held-down button after reset is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= button_n_in[i];
        sync2 <= sync1;
      end
    end

    assign pressed_sync = ~sync2;
    assign deb_flip     = (pressed_sync != level_q) && (deb_cnt == DEB_LAST);
    assign press_ev     = deb_flip & ~level_q;
    assign release_ev   = deb_flip & level_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_ev;
        release_q <= release_ev;
        if (pressed_sync == level_q) begin
          deb_cnt <= '0;
        end else if (deb_flip) begin
          deb_cnt <= '0;
          level_q <= ~level_q;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

    // The FSM acts on the same-cycle debounce events so its pulses line up with press/release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        hold_cnt <= '0;
        click_q  <= 1'b0;
        long_q   <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
        double_q <= 1'b0;
        win_cnt  <= '0;
`endif
      end else begin
        click_q  <= 1'b0;
        long_q   <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
        double_q <= 1'b0;
`endif
        case (state_q)
          IDLE: begin
            if (press_ev) begin
              state_q  <= HELD;
              hold_cnt <= '0;
            end
          end
          HELD: begin
            if (release_ev) begin
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
              state_q <= WAIT2;
              win_cnt <= '0;
`else
              state_q <= IDLE;
              click_q <= 1'b1;
`endif
            end else if (hold_cnt == LONG_LAST) begin
              long_q  <= 1'b1;
              state_q <= LONG;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          LONG: begin
            if (release_ev) state_q <= IDLE;
          end
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
          WAIT2: begin
            if (press_ev) begin
              double_q <= 1'b1;
              state_q  <= HELD2;
            end else if (win_cnt == WIN_LAST) begin
              click_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
          HELD2: begin
            if (release_ev) state_q <= IDLE;
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end

    assign level[i]         = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign click_pulse[i]   = click_q;
    assign long_pulse[i]    = long_q;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
    assign double_pulse[i]  = double_q;
`else
    assign double_pulse[i]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_event_debouncer.sv
// Bench for button_event_debouncer: scenario table, timing sequences, async reset and random stimulus vs a timestamp model.
// Expectations follow BUTTON_EVENT_DOUBLE_PRESS_EN when it is defined for the whole build.
module tb_button_event_debouncer;
  localparam int CH     = 2;
  localparam int DEB    = 4;
  localparam int LONG_C = 20;
  localparam int WIN    = 10;
  localparam int W      = 6 * CH;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] button_n_in = '1;
  logic [CH-1:0] level, press_pulse, release_pulse, click_pulse, double_pulse, long_pulse;

  always #5 clk = ~clk;

  button_event_debouncer #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG_C),
    .DOUBLE_WINDOW(WIN), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button_n_in(button_n_in),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .click_pulse(click_pulse), .double_pulse(double_pulse), .long_pulse(long_pulse)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic logic [W-1:0] act_vec();
    return {level, press_pulse, release_pulse, click_pulse, double_pulse, long_pulse};
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", name, act, exp);
  endtask

  // ---------------- reference model (timestamps per channel) ----------------
  logic m_d1[CH], m_d2[CH], m_level[CH];
  int   m_since[CH], m_press_t[CH], m_rel_t[CH];
  bit   m_hold[CH], m_await[CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_d1[c] = 1'b1; m_d2[c] = 1'b1; m_level[c] = 1'b0;
      m_since[c] = -1; m_press_t[c] = 0; m_rel_t[c] = 0;
      m_hold[c] = 1'b0; m_await[c] = 1'b0;
    end
  endfunction

  // Expected outputs right after the clock edge numbered cyc, given the pins sampled at that edge.
  function automatic logic [W-1:0] model_step(input logic [CH-1:0] pins);
    logic [CH-1:0] lv, pr, rl, ck, db, lg;
    lv = '0; pr = '0; rl = '0; ck = '0; db = '0; lg = '0;
    for (int c = 0; c < CH; c++) begin
      logic view, was, flip;
      view = ~m_d2[c];
      m_d2[c] = m_d1[c];
      m_d1[c] = pins[c];
      was  = m_level[c];
      flip = 1'b0;
      if (view == m_level[c]) m_since[c] = -1;
      else begin
        if (m_since[c] < 0) m_since[c] = cyc;
        if (cyc - m_since[c] + 1 >= DEB) begin
          flip = 1'b1;
          m_level[c] = ~m_level[c];
          m_since[c] = -1;
        end
      end
      pr[c] = flip & ~was;
      rl[c] = flip & was;
      if (rl[c]) begin
        if (m_hold[c]) begin
          m_hold[c] = 1'b0;
          if (DBL_EN) begin m_await[c] = 1'b1; m_rel_t[c] = cyc; end
          else ck[c] = 1'b1;
        end
      end else if (m_hold[c] && (cyc - m_press_t[c] == LONG_C)) begin
        lg[c] = 1'b1;
        m_hold[c] = 1'b0;
      end
      if (pr[c]) begin
        if (m_await[c]) begin db[c] = 1'b1; m_await[c] = 1'b0; end
        else begin m_hold[c] = 1'b1; m_press_t[c] = cyc; end
      end else if (m_await[c] && (cyc - m_rel_t[c] == WIN)) begin
        ck[c] = 1'b1;
        m_await[c] = 1'b0;
      end
      lv[c] = m_level[c];
    end
    return {lv, pr, rl, ck, db, lg};
  endfunction

  // ---------------- driver tasks ----------------
  int ev_press[$], ev_rel[$], ev_click[$], ev_dbl[$], ev_long[$];
  logic [5:0] ch1_seen;

  function automatic int t_of(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -100000;
  endfunction

  // Starts and ends on a falling edge: drive, clock, then check away from the edge.
  task automatic tick(input logic [CH-1:0] pins);
    logic [W-1:0] e, a;
    button_n_in = pins;
    @(posedge clk);
    cyc++;
    exp_q.push_back(model_step(pins));
    @(negedge clk);
    a = act_vec();
    e = exp_q.pop_front();
    check_vec("cycle", a, e);
    if (press_pulse[0])   ev_press.push_back(cyc);
    if (release_pulse[0]) ev_rel.push_back(cyc);
    if (click_pulse[0])   ev_click.push_back(cyc);
    if (double_pulse[0])  ev_dbl.push_back(cyc);
    if (long_pulse[0])    ev_long.push_back(cyc);
    ch1_seen |= {level[1], press_pulse[1], release_pulse[1], click_pulse[1], double_pulse[1], long_pulse[1]};
  endtask

  task automatic clear_events();
    ev_press.delete(); ev_rel.delete(); ev_click.delete(); ev_dbl.delete(); ev_long.delete();
    ch1_seen = '0;
  endtask

  // ch0 pin: low low1, high high1, low low2, then high tail; ch1 stays released.
  task automatic run_row(input int low1, input int high1, input int low2, input int tail);
    clear_events();
    repeat (low1)  tick(2'b10);
    repeat (high1) tick(2'b11);
    repeat (low2)  tick(2'b10);
    repeat (tail)  tick(2'b11);
  endtask

  typedef struct {
    string name;
    int low1, high1, low2, tail;
    int e_press, e_rel, e_click, e_dbl, e_long;
  } row_t;

  row_t rows[8];
  int   t0;
  logic [CH-1:0] rpins;
  int   hold_left[CH];

  initial begin
    rows[0] = '{"bounce",      3,  2,  3, 20, 0, 0, 0, 0, 0};
    rows[1] = '{"click",      10,  0,  0, 30, 1, 1, 1, 0, 0};
    rows[2] = '{"double",     10,  5, 40, 30, 2, 2, DBL_EN ? 0 : 1, DBL_EN ? 1 : 0, DBL_EN ? 0 : 1};
    rows[3] = '{"long",       30,  0,  0, 30, 1, 1, 0, 0, 1};
    rows[4] = '{"rel_at_long",20,  0,  0, 30, 1, 1, 1, 0, 0};
    rows[5] = '{"just_long",  21,  0,  0, 30, 1, 1, 0, 0, 1};
    rows[6] = '{"win_edge",   10, 10,  5, 30, 2, 2, DBL_EN ? 0 : 2, DBL_EN ? 1 : 0, 0};
    rows[7] = '{"win_missed", 10, 11,  5, 30, 2, 2, 2, 0, 0};

    // reset state
    model_reset();
    repeat (3) @(negedge clk);
    check_vec("reset_state", act_vec(), '0);
    rst_n = 1'b1;
    cyc = 0;

    // table-driven scenarios
    for (int r = 0; r < 8; r++) begin
      run_row(rows[r].low1, rows[r].high1, rows[r].low2, rows[r].tail);
      check_int({rows[r].name, "_press"},  ev_press.size(), rows[r].e_press);
      check_int({rows[r].name, "_rel"},    ev_rel.size(),   rows[r].e_rel);
      check_int({rows[r].name, "_click"},  ev_click.size(), rows[r].e_click);
      check_int({rows[r].name, "_double"}, ev_dbl.size(),   rows[r].e_dbl);
      check_int({rows[r].name, "_long"},   ev_long.size(),  rows[r].e_long);
      check_int({rows[r].name, "_ch1"},    int'(ch1_seen),  0);
    end

    // clean press / click timing
    t0 = cyc;
    run_row(10, 0, 0, 30);
    check_int("clean_press_t", t_of(ev_press, 0) - t0, 6);
    check_int("clean_rel_t",   t_of(ev_rel, 0) - t0, 16);
    check_int("click_t",       t_of(ev_click, 0) - t0, DBL_EN ? 26 : 16);

    // second press 5 cycles after the first release pulse, then held 40 cycles
    t0 = cyc;
    run_row(10, 5, 40, 30);
    check_int("second_press_t", t_of(ev_press, 1) - t0, 21);
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
    check_int("double_t", t_of(ev_dbl, 0) - t0, 21);
    check_int("double_no_long", ev_long.size(), 0);
`else
    check_int("single_click_t", t_of(ev_click, 0) - t0, 16);
    check_int("second_long_t", t_of(ev_long, 0) - t0, 41);
`endif

    // long press timing
    t0 = cyc;
    run_row(30, 0, 0, 30);
    check_int("long_t", t_of(ev_long, 0) - t0, 26);
    check_int("long_rel_t", t_of(ev_rel, 0) - t0, 36);
    check_int("long_no_click", ev_click.size(), 0);

    // asynchronous reset 5 cycles into a hold, pin kept low through reset
    clear_events();
    repeat (11) tick(2'b10);
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", act_vec(), '0);
    @(negedge clk);
    @(negedge clk);
    check_vec("in_reset", act_vec(), '0);
    rst_n = 1'b1;
    model_reset();
    clear_events();
    t0 = cyc;
    repeat (8) tick(2'b10);
    check_int("press_after_reset_t", t_of(ev_press, 0) - t0, 6);
    repeat (30) tick(2'b11);

    // random stimulus on both channels
    rpins = '1;
    for (int c = 0; c < CH; c++) hold_left[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold_left[c] == 0) begin
          rpins[c] = ~rpins[c];
          hold_left[c] = $urandom_range(1, 35);
        end else begin
          hold_left[c]--;
        end
      end
      tick(rpins);
    end
    repeat (40) tick('1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
